// File: rtl/mc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// mc_ctrl_pkg
// Purpose : Shared types and encodings for the multicycle ARM control unit:
//           FSM state enum, ALUControl codes, cmd/Op field encodings and the
//           Moore output bundle (with the FETCH values used out of reset).
// Ports   : none (package)
// ----------------------------------------------------------------------------
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BRANCH,
        S_MULEX
    } state_t;

    // ALUControl codes (zero-extended to ALUCTRL_W at the top level)
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;

    // Data-processing cmd field, Funct[4:1]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Op field, Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] MUL_INSTR74 = 4'b1001;

    // Moore outputs of the main FSM
    typedef struct packed {
        logic       irWrite;
        logic       nextPc;
        logic       adrSrc;
        logic [1:0] resultSrc;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic       regW;
        logic       memW;
        logic       branch;
        logic       aluOp;
        logic       busy;
    } fsm_out_t;

    // FETCH: load IR, PC <= PC+4 computed by the ALU (PC + const 4)
    localparam fsm_out_t FETCH_OUTPUTS = '{
        irWrite:   1'b1,
        nextPc:    1'b1,
        adrSrc:    1'b0,
        resultSrc: 2'b10,
        aluSrcA:   2'b01,
        aluSrcB:   2'b10,
        regW:      1'b0,
        memW:      1'b0,
        branch:    1'b0,
        aluOp:     1'b0,
        busy:      1'b0
    };

endpackage

// File: rtl/mc_main_fsm.sv
// ----------------------------------------------------------------------------
// mc_main_fsm
// Purpose : Main multicycle state machine: state register, MUL latency
//           counter and the Moore control outputs of each state.
// Ports   : i_clk, i_rst        clock, async active-high reset
//           i_op                Instr[27:26]
//           i_immFlag           Funct[5] (I bit), picks EXECUTEI
//           i_loadFlag          Funct[0] (L bit), LDR vs STR
//           i_isMul             MUL decoded (already gated by MUL_EN)
//           i_noWb              suppress RegW in ALUWB (CMP/TST/CMN/unlisted)
//           o_ctrl              Moore output bundle
// ----------------------------------------------------------------------------
module mc_main_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_op,
    input  logic       i_immFlag,
    input  logic       i_loadFlag,
    input  logic       i_isMul,
    input  logic       i_noWb,
    output fsm_out_t   o_ctrl
);

    // Reload value: the counter hits zero in the last MULEX cycle
    localparam logic [3:0] LAT_RELOAD = 4'(MUL_LAT - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_mulCnt;
    logic [3:0] w_nextCnt;

    // State and MUL counter registers; reset restarts the instruction at FETCH
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_FETCH;
            r_mulCnt <= 4'd0;
        end else begin
            r_state  <= w_nextState;
            r_mulCnt <= w_nextCnt;
        end
    end

    // Next-state logic; the MUL counter reloads on entry to MULEX and counts down
    always_comb begin
        w_nextState = S_FETCH;
        w_nextCnt   = r_mulCnt;
        case (r_state)
            S_FETCH: w_nextState = S_DECODE;
            S_DECODE: begin
                case (i_op)
                    OP_MEM: w_nextState = S_MEMADR;
                    OP_BR:  w_nextState = S_BRANCH;
                    OP_DP: begin
                        if (i_isMul) begin
                            w_nextState = S_MULEX;
                            w_nextCnt   = LAT_RELOAD;
                        end else if (i_immFlag) begin
                            w_nextState = S_EXECUTEI;
                        end else begin
                            w_nextState = S_EXECUTER;
                        end
                    end
                    default: w_nextState = S_FETCH;
                endcase
            end
            S_MEMADR:   w_nextState = i_loadFlag ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_nextState = S_MEMWB;
            S_EXECUTER: w_nextState = S_ALUWB;
            S_EXECUTEI: w_nextState = S_ALUWB;
            S_MULEX: begin
                if (r_mulCnt == 4'd0) begin
                    w_nextState = S_ALUWB;
                end else begin
                    w_nextState = S_MULEX;
                    w_nextCnt   = r_mulCnt - 4'd1;
                end
            end
            default: w_nextState = S_FETCH;
        endcase
    end

    // Moore outputs; everything not named in a state stays zero
    always_comb begin
        o_ctrl = '0;
        case (r_state)
            S_FETCH: o_ctrl = FETCH_OUTPUTS;
            S_DECODE: begin
                o_ctrl.resultSrc = 2'b10;
                o_ctrl.aluSrcA   = 2'b01;
                o_ctrl.aluSrcB   = 2'b10;
            end
            S_MEMADR:  o_ctrl.aluSrcB = 2'b01;
            S_MEMREAD: o_ctrl.adrSrc  = 1'b1;
            S_MEMWRITE: begin
                o_ctrl.adrSrc = 1'b1;
                o_ctrl.memW   = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.resultSrc = 2'b01;
                o_ctrl.regW      = 1'b1;
            end
            S_EXECUTER: o_ctrl.aluOp = 1'b1;
            S_EXECUTEI: begin
                o_ctrl.aluSrcB = 2'b01;
                o_ctrl.aluOp   = 1'b1;
            end
            S_ALUWB: o_ctrl.regW = !i_noWb;
            S_BRANCH: begin
                o_ctrl.aluSrcA   = 2'b10;
                o_ctrl.aluSrcB   = 2'b01;
                o_ctrl.resultSrc = 2'b10;
                o_ctrl.branch    = 1'b1;
            end
            S_MULEX: begin
                o_ctrl.aluOp = 1'b1;
                o_ctrl.busy  = 1'b1;
            end
            default: o_ctrl = FETCH_OUTPUTS;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// ----------------------------------------------------------------------------
// mc_ctrl_unit
// Purpose : Control unit of the multicycle ARM core: main FSM plus ALU
//           decoder, PC logic and instruction decoder.
// Ports   : clk, reset            clock, async active-high reset
//           Op, Funct, Rd, Instr74 instruction register fields
//           FlagW                 [1] NZ write, [0] CV write
//           PCS, NextPC, RegW, MemW  to condlogic
//           IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc,
//           ALUControl            datapath mux/ALU controls
//           Busy                  high while the multiplier runs
// ----------------------------------------------------------------------------
module mc_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int MUL_EN    = 1,
    parameter int MUL_LAT   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           Instr74,
    output logic [1:0]           FlagW,
    output logic                 PCS,
    output logic                 NextPC,
    output logic                 RegW,
    output logic                 MemW,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 Busy
);

    fsm_out_t   w_ctrl;
    logic       w_isMul;
    logic       w_noWb;
    logic [2:0] w_aluSel;
    logic [2:0] w_alu3;
    logic       w_noWrite;
    logic       w_arith;
    logic       w_listed;
    logic       w_sBit;

    assign w_isMul = (MUL_EN != 0) && (Op == OP_DP) && !Funct[5] && (Instr74 == MUL_INSTR74);

    // Compare/test ops and unknown cmds must not write the register file
    assign w_noWb = !w_isMul && (w_noWrite || !w_listed);

    mc_main_fsm #(
        .MUL_LAT(MUL_LAT)
    ) u_mainFsm (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_op      (Op),
        .i_immFlag (Funct[5]),
        .i_loadFlag(Funct[0]),
        .i_isMul   (w_isMul),
        .i_noWb    (w_noWb),
        .o_ctrl    (w_ctrl)
    );

    // cmd decode: ALU operation, arithmetic (CV-affecting) and no-writeback classes
    always_comb begin
        w_aluSel  = ALU_ADD;
        w_noWrite = 1'b0;
        w_arith   = 1'b0;
        w_listed  = 1'b1;
        case (Funct[4:1])
            CMD_ADD: begin w_aluSel = ALU_ADD; w_arith = 1'b1; end
            CMD_SUB: begin w_aluSel = ALU_SUB; w_arith = 1'b1; end
            CMD_AND: w_aluSel = ALU_AND;
            CMD_ORR: w_aluSel = ALU_ORR;
            CMD_EOR: w_aluSel = ALU_EOR;
            CMD_CMP: begin w_aluSel = ALU_SUB; w_arith = 1'b1; w_noWrite = 1'b1; end
            CMD_TST: begin w_aluSel = ALU_AND; w_noWrite = 1'b1; end
            CMD_CMN: begin w_aluSel = ALU_ADD; w_arith = 1'b1; w_noWrite = 1'b1; end
            default: w_listed = 1'b0;
        endcase
    end

    assign w_sBit = Funct[0] | w_noWrite;

    // ALU control and flag writes only in the cycle that produces ALUResult
    always_comb begin
        w_alu3 = ALU_ADD;
        FlagW  = 2'b00;
        if (w_ctrl.aluOp) begin
            if (w_isMul) begin
                w_alu3 = ALU_MUL;
                FlagW  = {Funct[0], 1'b0};
            end else if (w_listed) begin
                w_alu3 = w_aluSel;
                FlagW  = {w_sBit, w_sBit & w_arith};
            end
        end
    end

    assign ALUControl = ALUCTRL_W'(w_alu3);
    assign IRWrite    = w_ctrl.irWrite;
    assign NextPC     = w_ctrl.nextPc;
    assign AdrSrc     = w_ctrl.adrSrc;
    assign ResultSrc  = w_ctrl.resultSrc;
    assign ALUSrcA    = w_ctrl.aluSrcA;
    assign ALUSrcB    = w_ctrl.aluSrcB;
    assign RegW       = w_ctrl.regW;
    assign MemW       = w_ctrl.memW;
    assign Busy       = w_ctrl.busy;
    assign PCS        = w_ctrl.branch | ((Rd == 4'hF) & w_ctrl.regW);
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// ----------------------------------------------------------------------------
// tb_mc_ctrl_unit
// Purpose : Self-checking bench for mc_ctrl_unit. Two instances share the
//           instruction fields: dutA with MUL enabled (latency 4), dutB with
//           MUL disabled. An instruction-level model pushes the expected
//           per-cycle output vector to a scoreboard queue; each cycle pops
//           one entry and compares it against the selected instance(s).
// Vector  : {ImmSrc, RegSrc, IRWrite, NextPC, AdrSrc, ResultSrc, ALUSrcA,
//            ALUSrcB, RegW, MemW, PCS, FlagW, ALUControl, Busy}
// ----------------------------------------------------------------------------
module tb_mc_ctrl_unit;

    localparam int SEL_A    = 0;
    localparam int SEL_B    = 1;
    localparam int SEL_BOTH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] instr74;

    logic [1:0] flagWA, flagWB, resSrcA, resSrcB, srcAA, srcAB, srcBA, srcBB;
    logic [1:0] immA, immB, regSrcA, regSrcB;
    logic [2:0] aluA, aluB;
    logic       pcsA, pcsB, npcA, npcB, regWA, regWB, memWA, memWB;
    logic       irwA, irwB, adrA, adrB, busyA, busyB;
    logic [21:0] obsA, obsB;

    int errors = 0;
    int checks = 0;

    string       tagQ[$];
    logic [21:0] expQ[$];
    int          selQ[$];

    always #5 clk = ~clk;

    mc_ctrl_unit #(.ALUCTRL_W(3), .MUL_EN(1), .MUL_LAT(4)) dutA (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Rd(rd), .Instr74(instr74),
        .FlagW(flagWA), .PCS(pcsA), .NextPC(npcA), .RegW(regWA), .MemW(memWA),
        .IRWrite(irwA), .AdrSrc(adrA), .ResultSrc(resSrcA), .ALUSrcA(srcAA),
        .ALUSrcB(srcBA), .ImmSrc(immA), .RegSrc(regSrcA), .ALUControl(aluA), .Busy(busyA)
    );

    mc_ctrl_unit #(.ALUCTRL_W(3), .MUL_EN(0), .MUL_LAT(4)) dutB (
        .clk(clk), .reset(reset), .Op(op), .Funct(funct), .Rd(rd), .Instr74(instr74),
        .FlagW(flagWB), .PCS(pcsB), .NextPC(npcB), .RegW(regWB), .MemW(memWB),
        .IRWrite(irwB), .AdrSrc(adrB), .ResultSrc(resSrcB), .ALUSrcA(srcAB),
        .ALUSrcB(srcBB), .ImmSrc(immB), .RegSrc(regSrcB), .ALUControl(aluB), .Busy(busyB)
    );

    assign obsA = {immA, regSrcA, irwA, npcA, adrA, resSrcA, srcAA, srcBA,
                   regWA, memWA, pcsA, flagWA, aluA, busyA};
    assign obsB = {immB, regSrcB, irwB, npcB, adrB, resSrcB, srcAB, srcBB,
                   regWB, memWB, pcsB, flagWB, aluB, busyB};

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [17:0] cv(input logic irw, input logic npc, input logic adr,
                                       input logic [1:0] res, input logic [1:0] a,
                                       input logic [1:0] b, input logic regw,
                                       input logic memw, input logic pcs,
                                       input logic [1:0] fl, input logic [2:0] alu,
                                       input logic busy);
        return {irw, npc, adr, res, a, b, regw, memw, pcs, fl, alu, busy};
    endfunction

    task automatic checkOutput(input string tag, input logic [21:0] observed,
                               input logic [21:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic pushCycle(input string tag, input logic [17:0] v, input int sel);
        logic [3:0] src;
        src = {op, op == 2'b01, op == 2'b10};
        tagQ.push_back(tag);
        expQ.push_back({src, v});
        selQ.push_back(sel);
    endtask

    // Instruction-level reference: expected output vector for every cycle
    task automatic modelInstr(input string tag, input bit mulEn, input int sel);
        logic [3:0] cmd;
        logic [2:0] alu;
        bit         arith, noWr, listed, s, isMul;
        logic [1:0] fl;
        pushCycle({tag, " F"}, cv(1,1,0,2'b10,2'b01,2'b10,0,0,0,2'b00,3'b000,0), sel);
        pushCycle({tag, " D"}, cv(0,0,0,2'b10,2'b01,2'b10,0,0,0,2'b00,3'b000,0), sel);
        case (op)
            2'b01: begin
                pushCycle({tag, " MA"}, cv(0,0,0,2'b00,2'b00,2'b01,0,0,0,2'b00,3'b000,0), sel);
                if (funct[0]) begin
                    pushCycle({tag, " MR"}, cv(0,0,1,2'b00,2'b00,2'b00,0,0,0,2'b00,3'b000,0), sel);
                    pushCycle({tag, " MWB"}, cv(0,0,0,2'b01,2'b00,2'b00,1,0,rd == 4'hF,2'b00,3'b000,0), sel);
                end else begin
                    pushCycle({tag, " MW"}, cv(0,0,1,2'b00,2'b00,2'b00,0,1,0,2'b00,3'b000,0), sel);
                end
            end
            2'b10: pushCycle({tag, " BR"}, cv(0,0,0,2'b10,2'b10,2'b01,0,0,1,2'b00,3'b000,0), sel);
            2'b00: begin
                isMul = mulEn && !funct[5] && instr74 == 4'b1001;
                if (isMul) begin
                    for (int i = 0; i < 4; i++)
                        pushCycle({tag, " MX"}, cv(0,0,0,2'b00,2'b00,2'b00,0,0,0,{funct[0],1'b0},3'b101,1), sel);
                    pushCycle({tag, " WB"}, cv(0,0,0,2'b00,2'b00,2'b00,1,0,rd == 4'hF,2'b00,3'b000,0), sel);
                end else begin
                    cmd = funct[4:1];
                    arith = 0; noWr = 0; listed = 1; alu = 3'b000;
                    case (cmd)
                        4'b0100: begin alu = 3'b000; arith = 1; end
                        4'b0010: begin alu = 3'b001; arith = 1; end
                        4'b0000: alu = 3'b010;
                        4'b1100: alu = 3'b011;
                        4'b0001: alu = 3'b100;
                        4'b1010: begin alu = 3'b001; arith = 1; noWr = 1; end
                        4'b1000: begin alu = 3'b010; noWr = 1; end
                        4'b1011: begin alu = 3'b000; arith = 1; noWr = 1; end
                        default: listed = 0;
                    endcase
                    s  = funct[0] || noWr;
                    fl = listed ? {s, s && arith} : 2'b00;
                    pushCycle({tag, " EX"}, cv(0,0,0,2'b00,2'b00,funct[5] ? 2'b01 : 2'b00,0,0,0,fl,alu,0), sel);
                    pushCycle({tag, " WB"}, cv(0,0,0,2'b00,2'b00,2'b00,listed && !noWr,0,
                                               (rd == 4'hF) && listed && !noWr,2'b00,3'b000,0), sel);
                end
            end
            default: ;
        endcase
    endtask

    // Pops and compares one scoreboard entry per cycle, up to maxCycles entries
    task automatic runScoreboard(input int maxCycles);
        string       t;
        logic [21:0] e;
        int          s;
        for (int n = 0; n < maxCycles && tagQ.size() > 0; n++) begin
            t = tagQ.pop_front();
            e = expQ.pop_front();
            s = selQ.pop_front();
            #1;
            if (s != SEL_B) checkOutput({t, " A"}, obsA, e);
            if (s != SEL_A) checkOutput({t, " B"}, obsB, e);
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] o, input logic [5:0] f,
                                 input logic [3:0] r, input logic [3:0] i74, input int sel);
        op = o; funct = f; rd = r; instr74 = i74;
        modelInstr(tag, sel != SEL_B, sel);
        runScoreboard(32);
    endtask

    task automatic resetPulse(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        pushCycle({tag, " rst"}, cv(1,1,0,2'b10,2'b01,2'b10,0,0,0,2'b00,3'b000,0), SEL_BOTH);
        runScoreboard(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op = 2'b00; funct = 6'b0; rd = 4'd0; instr74 = 4'd0;
        #2;
        pushCycle("reset", cv(1,1,0,2'b10,2'b01,2'b10,0,0,0,2'b00,3'b000,0), SEL_BOTH);
        runScoreboard(1);
        reset = 1'b0;

        applyStimulus("ADD",    2'b00, 6'b001000, 4'd1,  4'b0000, SEL_BOTH);
        applyStimulus("SUBSi",  2'b00, 6'b100101, 4'd0,  4'b0000, SEL_BOTH);
        applyStimulus("LDR",    2'b01, 6'b011001, 4'd2,  4'b0000, SEL_BOTH);
        applyStimulus("STR",    2'b01, 6'b011000, 4'd3,  4'b0000, SEL_BOTH);
        applyStimulus("CMPr15", 2'b00, 6'b010101, 4'd15, 4'b0000, SEL_BOTH);
        applyStimulus("TST",    2'b00, 6'b010001, 4'd0,  4'b0000, SEL_BOTH);
        applyStimulus("CMN",    2'b00, 6'b010111, 4'd0,  4'b0000, SEL_BOTH);
        applyStimulus("ORRS",   2'b00, 6'b011001, 4'd4,  4'b0000, SEL_BOTH);
        applyStimulus("EOR",    2'b00, 6'b000010, 4'd5,  4'b0000, SEL_BOTH);
        applyStimulus("B",      2'b10, 6'b101000, 4'd0,  4'b0000, SEL_BOTH);
        applyStimulus("ADDr15", 2'b00, 6'b001000, 4'd15, 4'b0000, SEL_BOTH);
        applyStimulus("UNDEF",  2'b11, 6'b111111, 4'd15, 4'b1001, SEL_BOTH);
        applyStimulus("RSCunl", 2'b00, 6'b001110, 4'd7,  4'b0000, SEL_BOTH);
        applyStimulus("LDRr15", 2'b01, 6'b011001, 4'd15, 4'b0000, SEL_BOTH);

        // Reset in the middle of an LDR: back to FETCH, no MEMWB cycle
        op = 2'b01; funct = 6'b011001; rd = 4'd2; instr74 = 4'b0000;
        modelInstr("LDRrst", 1'b1, SEL_BOTH);
        runScoreboard(4);
        tagQ.delete(); expQ.delete(); selQ.delete();
        reset = 1'b1;
        #1;
        pushCycle("midrst async", cv(1,1,0,2'b10,2'b01,2'b10,0,0,0,2'b00,3'b000,0), SEL_BOTH);
        runScoreboard(1);
        pushCycle("midrst edge", cv(1,1,0,2'b10,2'b01,2'b10,0,0,0,2'b00,3'b000,0), SEL_BOTH);
        runScoreboard(1);
        reset = 1'b0;
        applyStimulus("STRpost", 2'b01, 6'b011000, 4'd3, 4'b0000, SEL_BOTH);

        // MUL on the MUL-enabled instance, then resync both with reset
        applyStimulus("MUL",  2'b00, 6'b000000, 4'd6,  4'b1001, SEL_A);
        applyStimulus("MULS", 2'b00, 6'b000001, 4'd15, 4'b1001, SEL_A);
        resetPulse("resync1");

        // Same encoding with MUL disabled decodes as a plain AND
        applyStimulus("MULoff", 2'b00, 6'b000000, 4'd6, 4'b1001, SEL_B);
        resetPulse("resync2");

        op = 2'b00; funct = 6'b001000; rd = 4'd1; instr74 = 4'b0000;
        pushCycle("final F", cv(1,1,0,2'b10,2'b01,2'b10,0,0,0,2'b00,3'b000,0), SEL_BOTH);
        runScoreboard(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
